// File: rtl/pipe_test_sequencer.sv
// Run sequencer for a pipe checker: resets it, loads the throttle, counts words
// and cycles, lets the pipe drain, then samples the error count and reports pass/fail.
module pipe_test_sequencer #(
  parameter int unsigned CLEAR_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_words,
  input  logic [31:0] cfg_throttle,
  input  logic [2:0]  cfg_pattern,
  input  logic [31:0] cfg_timeout,
  input  logic        pipe_in_write,
  input  logic [31:0] chk_error_count,
  output logic        chk_reset,
  output logic        chk_throttle_set,
  output logic [31:0] chk_throttle_val,
  output logic [2:0]  chk_pattern,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic        overrun,
  output logic        aborted,
  output logic [31:0] words_seen,
  output logic [31:0] cycles,
  output logic [31:0] err_latched
);

  localparam logic [3:0] CLEAR_LAST  = 4'(CLEAR_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    RUN,
    SETTLE,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  phase_cnt;
  logic [31:0] words_target;
  logic [31:0] timeout_val;
  logic [31:0] words_next;
  logic [31:0] cycles_next;

  // Saturating counters: the completion checks compare against post-increment values.
  always_comb begin
    words_next  = words_seen;
    cycles_next = cycles;
    if (pipe_in_write && (words_seen != 32'hFFFF_FFFF)) begin
      words_next = words_seen + 32'd1;
    end
    if (cycles != 32'hFFFF_FFFF) begin
      cycles_next = cycles + 32'd1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      phase_cnt        <= '0;
      words_target     <= '0;
      timeout_val      <= '0;
      chk_reset        <= 1'b1;
      chk_throttle_set <= 1'b0;
      chk_throttle_val <= '0;
      chk_pattern      <= '0;
      done             <= 1'b0;
      pass             <= 1'b0;
      timed_out        <= 1'b0;
      overrun          <= 1'b0;
      aborted          <= 1'b0;
      words_seen       <= '0;
      cycles           <= '0;
      err_latched      <= '0;
    end else begin
      chk_reset        <= 1'b0;
      chk_throttle_set <= 1'b0;
      done             <= 1'b0;
      if ((state != IDLE) && abort) begin
        state   <= IDLE;
        aborted <= 1'b1;
        pass    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              words_target     <= cfg_words;
              timeout_val      <= cfg_timeout;
              chk_throttle_val <= cfg_throttle;
              chk_pattern      <= cfg_pattern;
              words_seen       <= '0;
              cycles           <= '0;
              timed_out        <= 1'b0;
              overrun          <= 1'b0;
              aborted          <= 1'b0;
              pass             <= 1'b0;
              phase_cnt        <= '0;
              chk_reset        <= 1'b1;
              state            <= CLEAR;
            end
          end
          CLEAR: begin
            if (phase_cnt == CLEAR_LAST) begin
              chk_throttle_set <= 1'b1;
              state            <= ARM;
            end else begin
              chk_reset <= 1'b1;
              phase_cnt <= phase_cnt + 4'd1;
            end
          end
          ARM: begin
            phase_cnt <= '0;
            state     <= (words_target == 32'd0) ? SETTLE : RUN;
          end
          RUN: begin
            words_seen <= words_next;
            cycles     <= cycles_next;
            // Word completion wins over a timeout on the same edge.
            if (words_next == words_target) begin
              phase_cnt <= '0;
              state     <= SETTLE;
            end else if ((timeout_val != 32'd0) && (cycles_next == timeout_val)) begin
              timed_out <= 1'b1;
              phase_cnt <= '0;
              state     <= SETTLE;
            end
          end
          SETTLE: begin
            if (pipe_in_write) begin
              overrun <= 1'b1;
            end
            if (phase_cnt == SETTLE_LAST) begin
              err_latched <= chk_error_count;
              done        <= 1'b1;
              pass        <= (chk_error_count == 32'd0) && !timed_out
                             && !overrun && !pipe_in_write;
              state       <= DONE;
            end else begin
              phase_cnt <= phase_cnt + 4'd1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_test_sequencer.md
PIPE_TEST_SEQUENCER -- requirements
Module: pipe_test_sequencer

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 4: number of cycles chk_reset is held high per run (legal 1..15).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: number of drain cycles after the last word before the error count is sampled (legal 1..15).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle run request.
REQ-006 SHALL have port abort, input, 1: cancels a run in progress.
REQ-007 SHALL have port cfg_words, input, 32: number of pipe words expected in the run.
REQ-008 SHALL have port cfg_throttle, input, 32: throttle pattern forwarded to the checker.
REQ-009 SHALL have port cfg_pattern, input, 3: pattern-generator mode forwarded to the checker.
REQ-010 SHALL have port cfg_timeout, input, 32: maximum number of RUN cycles; 0 disables the timeout.
REQ-011 SHALL have port pipe_in_write, input, 1: word strobe, observed in parallel with the checker.
REQ-012 SHALL have port chk_error_count, input, 32: error counter from the checker.
REQ-013 SHALL have port chk_reset, output, 1: reset to the checker.
REQ-014 SHALL have port chk_throttle_set, output, 1: throttle load strobe to the checker.
REQ-015 SHALL have ports chk_throttle_val, output, 32, and chk_pattern, output, 3: configuration latched at start.
REQ-016 SHALL have ports busy, done, pass, timed_out, overrun and aborted, all outputs, 1: run status.
REQ-017 SHALL have ports words_seen, cycles and err_latched, all outputs, 32: run statistics.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ARM, RUN, SETTLE and DONE.
REQ-019 SHALL, in IDLE on start=1 with abort=0:
- latch cfg_* into internal and output registers;
- clear words_seen, cycles, timed_out, overrun, aborted and pass;
- enter CLEAR on the next edge.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL drive chk_reset=1 for exactly CLEAR_CYCLES cycles while in CLEAR, then enter ARM.
REQ-022 SHALL drive chk_throttle_set=1 for exactly one cycle while in ARM, then enter RUN.
REQ-023 SHALL, in RUN, increment words_seen on each pipe_in_write and increment cycles every cycle; both SHALL saturate at 0xFFFFFFFF.
REQ-024 SHALL enter SETTLE on the edge where words_seen reaches the latched cfg_words; the check SHALL be against the post-increment value.
REQ-025 SHALL go from ARM directly to SETTLE when the latched cfg_words=0.
REQ-026 SHALL, in RUN with latched cfg_timeout≠0, set timed_out=1 and enter SETTLE when cycles reaches cfg_timeout.
REQ-027 SHALL give word completion priority over timeout when both occur on the same edge; timed_out then stays 0.
REQ-028 SHALL set overrun=1 on any pipe_in_write observed in SETTLE; it is sticky until the next start.
REQ-029 SHALL ignore pipe_in_write in IDLE, CLEAR, ARM and DONE; it does not count toward words_seen.
REQ-030 SHALL, after SETTLE_CYCLES cycles in SETTLE:
- register err_latched <= chk_error_count;
- enter DONE.
REQ-031 SHALL, in DONE:
- pulse done=1 for one cycle;
- set pass = (err_latched==0) && !timed_out && !overrun;
- return to IDLE.
REQ-032 SHALL hold busy=1 in every state except IDLE.
REQ-033 SHALL hold pass, timed_out, overrun, aborted, words_seen, cycles and err_latched stable in IDLE until the next accepted start.
REQ-034 SHALL, on abort=1 in any non-IDLE state:
- return to IDLE on the next edge;
- set aborted=1 and pass=0;
- keep done=0;
- deassert chk_reset and chk_throttle_set.
REQ-035 SHALL give abort priority over start when both are asserted in IDLE; no run begins, and aborted is unchanged.

Reset
REQ-036 SHALL, on reset=1:
- enter IDLE;
- drive chk_reset=1 for that cycle only;
- set all other 1-bit outputs to 0;
- set all 32-bit outputs and chk_pattern to 0.
REQ-037 SHALL, when reset is asserted mid-run, discard the run with no done pulse, and accept start on the first cycle after reset deasserts.

Verification
REQ-038 Bench SHALL cover: start with cfg_words=8, cfg_throttle=0xFFFFFFFF, 8 writes, chk_error_count=0 -> chk_reset high for 4 cycles, chk_throttle_set for 1 cycle, words_seen=8, done pulse, pass=1.
REQ-039 Bench SHALL cover: same as REQ-038 but chk_error_count=3 at sampling -> err_latched=3, pass=0.
REQ-040 Bench SHALL cover: cfg_words=100, cfg_timeout=50, only 10 writes -> timed_out=1, cycles=50, words_seen=10, pass=0.
REQ-041 Bench SHALL cover: cfg_words=4 with a 5th write in SETTLE -> overrun=1, pass=0; start pulsed during RUN is ignored.
REQ-042 Bench SHALL cover: abort during RUN after 3 writes -> IDLE next cycle, aborted=1, done never asserted, words_seen=3.
REQ-043 Bench SHALL cover: cfg_words=0 -> sequence CLEAR, ARM, SETTLE, DONE; pass=1; reset mid-CLEAR -> IDLE with no done pulse.
